// File: rtl/cost_function_unit_if.sv
// Bundle between the output perceptron, the cost unit and the network training port.
// master = perceptron/network side, slave = cost_function_unit.
interface cost_function_unit_if #(
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int ERRCNT_W = 16
);
  localparam int BITWIDTH = QN + QM + 1;

  logic                       dataReadyP;
  logic signed [BITWIDTH-1:0] networkOutput;
  logic                       modelOutput;
  logic                       countEn;
  logic                       clearErr;
  logic        [BITWIDTH-1:0] costFunc;
  logic                       newCostFunc;
  logic                       predBit;
  logic                       busy;
  logic                       overrun;
  logic        [ERRCNT_W-1:0] errCount;

  modport master (
    output dataReadyP, networkOutput, modelOutput, countEn, clearErr,
    input  costFunc, newCostFunc, predBit, busy, overrun, errCount
  );

  modport slave (
    input  dataReadyP, networkOutput, modelOutput, countEn, clearErr,
    output costFunc, newCostFunc, predBit, busy, overrun, errCount
  );
endinterface

// File: rtl/cost_function_unit.sv
// PLAN-sigmoid squared-error cost unit feeding the LSTM training port.
// Optional mismatch counter enabled by defining COSTFN_ERR_COUNT_EN.
module cost_function_unit #(
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int ERRCNT_W = 16
) (
  input logic                 clock,
  input logic                 reset,
  cost_function_unit_if.slave bus
);
  localparam int BITWIDTH = QN + QM + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SIG    = 3'd1;
  localparam logic [2:0] SQR    = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] STROBE = 3'd4;

  localparam logic [BITWIDTH-1:0] ONE_W   = BITWIDTH'(1 << QM);
  localparam logic [BITWIDTH-1:0] SAT_A   = BITWIDTH'(5 << QM);
  localparam logic [BITWIDTH-1:0] MID_A   = BITWIDTH'(19 << (QM - 3));
  localparam logic [BITWIDTH-1:0] OFF_HI  = BITWIDTH'(27 << (QM - 5));
  localparam logic [BITWIDTH-1:0] OFF_MID = BITWIDTH'(5 << (QM - 3));
  localparam logic [BITWIDTH-1:0] OFF_LO  = BITWIDTH'(1 << (QM - 1));
  localparam logic [BITWIDTH-1:0] MAX_POS = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] MOST_NEG = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [QM:0] ONE_S = (QM+1)'(1 << QM);
  localparam logic [QM:0] HALF_S = (QM+1)'(1 << (QM - 1));

  // Piecewise-linear sigmoid; |most negative| saturates to the largest positive magnitude.
  function automatic logic [QM:0] plan_sigmoid(input logic signed [BITWIDTH-1:0] x);
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] y;
    logic                neg;
    neg = x[BITWIDTH-1];
    if (x == MOST_NEG)
      a = MAX_POS;
    else if (neg)
      a = $unsigned(-x);
    else
      a = $unsigned(x);
    if (a >= SAT_A)
      y = ONE_W;
    else if (a >= MID_A)
      y = (a >> 5) + OFF_HI;
    else if (a >= ONE_W)
      y = (a >> 3) + OFF_MID;
    else
      y = (a >> 2) + OFF_LO;
    return (QM+1)'(neg ? ONE_W - y : y);
  endfunction

  function automatic logic [BITWIDTH-1:0] sq_cost(input logic [QM:0] sig, input logic tgt);
    logic [QM:0]     d;
    logic [2*QM+1:0] dd;
    d  = tgt ? ONE_S - sig : sig;
    dd = (2*QM+2)'(d);
    return BITWIDTH'((dd * dd) >> QM);
  endfunction

  logic [2:0]                 state;
  logic                       rdy_q;
  logic                       start;
  logic signed [BITWIDTH-1:0] x_p0;
  logic                       tgt_p0;
  logic [QM:0]                sig_next;
  logic [QM:0]                sig_p1;
  logic [BITWIDTH-1:0]        cost_p2;
  logic                       strobe;
  logic                       pred;
  logic                       busy;
  logic                       overrun;
  logic [ERRCNT_W-1:0]        err_count;

  assign start    = bus.dataReadyP & ~rdy_q;
  assign sig_next = plan_sigmoid(x_p0);

  // Stage p0/p1 data capture (no reset: qualified by the FSM)
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      x_p0   <= bus.networkOutput;
      tgt_p0 <= bus.modelOutput;
    end
    if (state == SIG)
      sig_p1 <= sig_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      cost_p2 <= '0;
      strobe  <= 1'b0;
      pred    <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rdy_q  <= bus.dataReadyP;
      strobe <= 1'b0;
      if (start && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SIG;
            busy  <= 1'b1;
          end
        end
        SIG: begin
          pred  <= (sig_next >= HALF_S);
          state <= SQR;
        end
        // Stage p2: cost registered here so it is stable a full cycle before the strobe
        SQR: begin
          cost_p2 <= sq_cost(sig_p1, tgt_p0);
          state   <= HOLD;
        end
        HOLD: begin
          strobe <= 1'b1;
          state  <= STROBE;
        end
        STROBE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COSTFN_ERR_COUNT_EN
  logic cnt_en_p0;

  always_ff @(posedge clock) begin
    if (state == IDLE && start)
      cnt_en_p0 <= bus.countEn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if (bus.clearErr)
      err_count <= '0;
    else if (state == STROBE && cnt_en_p0 && (pred != tgt_p0) && (err_count != '1))
      err_count <= err_count + ERRCNT_W'(1);
  end
`else
  logic unused_ctl;
  assign unused_ctl = bus.countEn ^ bus.clearErr;
  assign err_count  = '0;
`endif

  assign bus.costFunc    = cost_p2;
  assign bus.newCostFunc = strobe;
  assign bus.predBit     = pred;
  assign bus.busy        = busy;
  assign bus.overrun     = overrun;
  assign bus.errCount    = err_count;
endmodule

// File: tb/tb_cost_function_unit.sv
// Randomized self-checking bench for cost_function_unit against an integer
// reference of the PLAN sigmoid / squared-error cost.
module tb_cost_function_unit;
  localparam int QN  = 6;
  localparam int QM  = 11;
  localparam int EW  = 16;
  localparam int ONE = 1 << QM;
`ifdef COSTFN_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;
  int   exp_err;

  cost_function_unit_if #(.QN(QN), .QM(QM), .ERRCNT_W(EW)) bus ();

  cost_function_unit #(.QN(QN), .QM(QM), .ERRCNT_W(EW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: sigmoid value and cost computed from the segment rules with integer math.
  function automatic void ref_model(input int v, input bit tgt, output int sig, output int cost);
    int a;
    int y;
    int d;
    a = (v < 0) ? -v : v;
    if (a > (1 << (QN + QM)) - 1) a = (1 << (QN + QM)) - 1;
    if (a >= 5 * ONE)                y = ONE;
    else if (a >= 19 * ONE / 8)      y = a / 32 + 27 * ONE / 32;
    else if (a >= ONE)               y = a / 8 + 5 * ONE / 8;
    else                             y = a / 4 + ONE / 2;
    sig  = (v < 0) ? ONE - y : y;
    d    = tgt ? ONE - sig : sig;
    cost = (d * d) / ONE;
  endfunction

  task automatic run_txn(input int v, input bit tgt, input bit ce, input bit clr, input string tag);
    int sig;
    int cost;
    bit p;
    ref_model(v, tgt, sig, cost);
    p = (sig >= ONE / 2);
    @(negedge clock);
    bus.networkOutput = 18'(v);
    bus.modelOutput   = tgt;
    bus.countEn       = ce;
    bus.dataReadyP    = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_busy"}, bus.busy, 1);
    @(negedge clock);
    bus.dataReadyP    = 1'b0;
    bus.networkOutput = 18'($urandom);
    bus.modelOutput   = 1'($urandom);
    bus.countEn       = 1'($urandom);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_early"}, bus.newCostFunc, 0);
    @(posedge clock); #1;
    chk({tag, "_strobe"}, bus.newCostFunc, 1);
    chk({tag, "_cost"}, bus.costFunc, cost);
    chk({tag, "_pred"}, bus.predBit, p);
    if (clr) begin
      @(negedge clock);
      bus.clearErr = 1'b1;
    end
    @(posedge clock); #1;
    bus.clearErr = 1'b0;
    if (ERR_EN) begin
      if (clr) exp_err = 0;
      else if (ce && (p != tgt) && exp_err < (1 << EW) - 1) exp_err++;
    end
    chk({tag, "_done"}, bus.newCostFunc, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_errcnt"}, bus.errCount, exp_err);
  endtask

  initial begin
    int strobes;
    int last_cost;
    int v;
    n_chk = 0; n_err = 0; exp_err = 0;
    reset = 1'b1;
    bus.dataReadyP = 1'b0; bus.networkOutput = '0; bus.modelOutput = 1'b0;
    bus.countEn = 1'b0; bus.clearErr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cost", bus.costFunc, 0);
    chk("rst_strobe", bus.newCostFunc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_pred", bus.predBit, 0);
    chk("rst_err", bus.errCount, 0);
    @(negedge clock); reset = 1'b0;

    run_txn(0, 1'b1, 1'b1, 1'b0, "zero");
    run_txn(2048, 1'b0, 1'b1, 1'b0, "one");
    run_txn(1024, 1'b0, 1'b0, 1'b0, "half");
    run_txn(-10240, 1'b1, 1'b1, 1'b0, "neg5");
    run_txn(-131072, 1'b0, 1'b1, 1'b0, "mostneg");
    run_txn(131071, 1'b1, 1'b1, 1'b0, "maxpos");
    run_txn(4864, 1'b0, 1'b1, 1'b0, "midedge");
    run_txn(10239, 1'b1, 1'b1, 1'b0, "satedge");
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 12000));
      if ($urandom_range(0, 1) == 1) v = -v;
      run_txn(v, 1'($urandom), 1'($urandom), 1'b0, "rand");
    end
    chk("no_overrun", bus.overrun, 0);

    // second edge two cycles after the first: one strobe, overrun flagged
    @(negedge clock);
    bus.networkOutput = 18'(1024); bus.modelOutput = 1'b0; bus.dataReadyP = 1'b1;
    strobes = 0; last_cost = -1;
    @(posedge clock);
    @(negedge clock); bus.dataReadyP = 1'b0;
    @(posedge clock);
    @(negedge clock); bus.dataReadyP = 1'b1; bus.networkOutput = 18'(0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (bus.newCostFunc) begin strobes++; last_cost = int'(bus.costFunc); end
    end
    chk("ovr_strobes", strobes, 1);
    chk("ovr_cost", last_cost, 800);
    chk("ovr_flag", bus.overrun, 1);
    @(negedge clock); bus.dataReadyP = 1'b0;
    repeat (2) @(posedge clock);

    // level held high for 10 cycles launches only once
    @(negedge clock);
    bus.networkOutput = 18'(2048); bus.modelOutput = 1'b0; bus.dataReadyP = 1'b1;
    strobes = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) begin @(negedge clock); bus.dataReadyP = 1'b0; end
      @(posedge clock); #1;
      if (bus.newCostFunc) begin strobes++; last_cost = int'(bus.costFunc); end
    end
    chk("held_strobes", strobes, 1);
    chk("held_cost", last_cost, 1152);

    // reset while in SQR aborts the computation
    @(negedge clock);
    bus.networkOutput = 18'(2048); bus.modelOutput = 1'b0; bus.dataReadyP = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_cost", bus.costFunc, 0);
    chk("abort_strobe", bus.newCostFunc, 0);
    chk("abort_overrun", bus.overrun, 0);
    exp_err = 0;
    @(negedge clock); bus.dataReadyP = 1'b0;
    @(negedge clock); reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (bus.newCostFunc) strobes++;
    end
    chk("abort_nostrobe", strobes, 0);
    run_txn(1024, 1'b0, 1'b1, 1'b0, "post_rst");

    // clearErr coinciding with a counted mismatch
    run_txn(2048, 1'b0, 1'b1, 1'b0, "pre_clr");
    run_txn(2048, 1'b0, 1'b1, 1'b1, "clr");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cost_function_unit.md
Name: cost_function_unit

Overview:
- Hardware replacement for the real-valued cost computation that currently feeds the LSTM network's training port.
- Sits directly downstream of the output perceptron (array_prod) and upstream of network's costFunc/newCostFunc inputs.
- Takes the perceptron's Q(QN.QM) output and applies a piecewise-linear (PLAN) sigmoid.
- Computes squared error against the 1-bit target, then emits a single-cycle newCostFunc strobe with the fixed-point cost.

Parameters:
- QN, 6, integer bits of fixed-point format.
- QM, 11, fractional bits of fixed-point format (QM >= 5).
- BITWIDTH, QN+QM+1, word width (derived; do not override).
- ERRCNT_W, 16, width of mismatch counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dataReadyP  in  1  perceptron result valid (level; rising edge starts a computation).
- networkOutput  in  BITWIDTH  perceptron output, signed Q(QN.QM).
- modelOutput  in  1  target bit for current sample.
- countEn  in  1  when high at start, mismatch is counted (nominal pass only).
- clearErr  in  1  synchronous clear of errCount.
- costFunc  out  BITWIDTH  unsigned cost, Q(QN.QM), range 0..2^QM.
- newCostFunc  out  1  one-cycle strobe, costFunc valid.
- predBit  out  1  rounded sigmoid (sig >= 2^(QM-1)).
- busy  out  1  computation in progress.
- overrun  out  1  sticky: rising edge of dataReadyP seen while busy.
- errCount  out  ERRCNT_W  mismatches predBit != modelOutput.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, edge-detect register cleared; assertion mid-computation aborts with no strobe.
- Edge detect: start = dataReadyP & ~dataReadyP_q. Only start launches work; held-high level is ignored.
- FSM: IDLE -> SIG -> SQR -> HOLD -> STROBE -> IDLE, one cycle each.
  - IDLE: on start, latch networkOutput and modelOutput and countEn; busy=1.
  - SIG: a = |x|; most-negative input saturates to max positive. Then:
    - a >= 5<<QM: y = 1<<QM.
    - a >= 19<<(QM-3): y = (a>>5) + (27<<(QM-5)).
    - a >= 1<<QM: y = (a>>3) + (5<<(QM-3)).
    - else: y = (a>>2) + (1<<(QM-1)).
    - Shifts truncate. If x < 0, sig = (1<<QM) - y, else sig = y.
    - predBit registered here.
  - SQR: d = target ? (1<<QM) - sig : sig (unsigned, 0..2^QM). cost = (d*d) >> QM, truncating; full 2*(QM+1)-bit product; result <= 2^QM fits BITWIDTH.
  - HOLD: costFunc updated; one cycle settle, matching network's requirement that costFunc be stable a cycle before the strobe.
  - STROBE: newCostFunc=1 for exactly one cycle; busy deasserts on return to IDLE.
- Latency: newCostFunc rises exactly 4 clocks after the cycle in which start is detected.
- costFunc and predBit hold until next computation overwrites them.
- start while busy: ignored, overrun set (cleared only by reset).
- start in the same cycle as the return to IDLE is ignored (IDLE samples only from IDLE).
- clearErr wins over a simultaneous increment.

Optional Feature:
- Macro COSTFN_ERR_COUNT_EN.
- Defined: errCount increments (saturating at all-ones) in STROBE when latched countEn=1 and predBit != latched target.
- Undefined: counter logic absent, errCount tied to 0, countEn/clearErr unused.

Test Plan:
- networkOutput=0, target=1 -> sig=1024, predBit=1, costFunc=512, strobe 4 cycles after edge.
- networkOutput=2048 (1.0), target=0 -> sig=1536, costFunc=1152, predBit=1, errCount+1 when countEn=1 (macro on).
- networkOutput=1024 (0.5), target=0 -> sig=1280, costFunc=800; networkOutput=-10240 (-5.0), target=1 -> sig=0, costFunc=2048.
- networkOutput=18'h20000 (most negative), target=0 -> saturate, sig=0, costFunc=0; 18'h1FFFF, target=1 -> costFunc=0.
- Second dataReadyP edge 2 cycles after first -> single strobe for first value, overrun=1; dataReadyP held high 10 cycles -> one strobe only.
- reset asserted during SQR -> no strobe, costFunc=0, busy=0 immediately; next edge computes normally. clearErr with mismatch in same cycle -> errCount=0.
